dma_prefetch_scheduler: RTL and testbench

//  Arbitrates the single main-memory DMA port between demand RAM instructions (from execution) and prefetch requests (from the control unit INIT_PREFETCH step).

---
 rtl/dma_prefetch_scheduler.sv | 257 +++++++++++++++++++++++++
 tb/tb_dma_prefetch_scheduler.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_prefetch_scheduler.sv
// -----------------------------------------------------------------------------
// dma_prefetch_scheduler
//
// Purpose:
//   Shares the single main-memory DMA request port between demand transfers
//   (RAM instructions from execution) and prefetch transfers (queued by the
//   control unit's INIT_PREFETCH step). Prefetches wait in a small FIFO.
//   Demand normally wins; after STARVE_LIMIT consecutive demand grants taken
//   while a prefetch was waiting, the next grant goes to the prefetch. The
//   number of issued-but-unanswered transfers is capped at MAX_OUTSTANDING.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   pf_valid / pf_ready              prefetch push handshake (pf_ready = !full)
//   pf_cache_addr, pf_main_addr      prefetch payload (always a read)
//   dm_valid / dm_ready              demand request; dm_ready pulses for one
//                                    cycle once the demand has been captured
//   dm_cache_addr, dm_main_addr      demand payload
//   dm_is_write                      demand direction (1 = cache -> main)
//   flush                            drop all queued prefetches
//   mem_req_valid / mem_req_ready    request handshake toward the DMA engine
//   mem_req_cache, mem_req_main      request addresses
//   mem_req_write, mem_req_src       direction, source (0 demand, 1 prefetch)
//   mem_resp_valid, mem_resp_src     one transfer finished, and its source
//   dm_done                          one-cycle pulse after a demand completes
//   outstanding                      in-flight transfer count
// -----------------------------------------------------------------------------
module dma_prefetch_scheduler #(
  parameter int LOG_PF_DEPTH    = 2,
  parameter int MAX_OUTSTANDING = 4,
  parameter int STARVE_LIMIT    = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pf_valid,
  output logic        pf_ready,
  input  logic [17:0] pf_cache_addr,
  input  logic [17:0] pf_main_addr,
  input  logic        dm_valid,
  output logic        dm_ready,
  input  logic [17:0] dm_cache_addr,
  input  logic [17:0] dm_main_addr,
  input  logic        dm_is_write,
  input  logic        flush,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [17:0] mem_req_cache,
  output logic [17:0] mem_req_main,
  output logic        mem_req_write,
  output logic        mem_req_src,
  input  logic        mem_resp_valid,
  input  logic        mem_resp_src,
  output logic        dm_done,
  output logic [3:0]  outstanding
);

  localparam int PF_DEPTH = 1 << LOG_PF_DEPTH;
  localparam int CW       = LOG_PF_DEPTH + 1;
  localparam int SW       = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE_DM = 2'd1;
  localparam logic [1:0] ST_ISSUE_PF = 2'd2;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [17:0]             fifo_cache_mem [PF_DEPTH];
  logic [17:0]             fifo_main_mem  [PF_DEPTH];

  logic [LOG_PF_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG_PF_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;
  logic [1:0]              state_q, state_d;
  logic [SW-1:0]           starve_q, starve_d;
  logic [3:0]              outstanding_q, outstanding_d;
  logic [17:0]             req_cache_q, req_cache_d;
  logic [17:0]             req_main_q, req_main_d;
  logic                    req_write_q, req_write_d;
  logic                    req_src_q, req_src_d;
  logic                    dm_ready_q, dm_ready_d;
  logic                    dm_done_q, dm_done_d;

  // ---------------------------------------------------------------------------
  // Decision signals
  // ---------------------------------------------------------------------------
  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic slot_free;
  logic pf_avail;
  logic take_pf;
  logic take_dm;
  logic req_hs;
  logic resp_ok;

  always_comb begin
    fifo_full  = (count_q == CW'(PF_DEPTH));
    fifo_empty = (count_q == '0);
    // A flush cycle discards any push offered alongside it.
    push       = pf_valid && !fifo_full && !flush;
    // Only the registered count matters: a response arriving this cycle does
    // not free a slot until the next cycle.
    slot_free  = (outstanding_q < 4'(MAX_OUTSTANDING));
    // Queued prefetches are being dropped on a flush cycle, so none may be
    // granted out of the queue in that same cycle.
    pf_avail   = !fifo_empty && !flush;
    take_pf    = (state_q == ST_IDLE) && slot_free && pf_avail &&
                 ((starve_q == SW'(STARVE_LIMIT)) || !dm_valid);
    take_dm    = (state_q == ST_IDLE) && slot_free && !take_pf && dm_valid;
    req_hs     = mem_req_valid && mem_req_ready;
    // A response with nothing in flight is stale and is ignored entirely.
    resp_ok    = mem_resp_valid && (outstanding_q != 4'd0);
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + LOG_PF_DEPTH'(1);
      end
      if (take_pf) begin
        rd_ptr_d = rd_ptr_q + LOG_PF_DEPTH'(1);
      end
      case ({push, take_pf})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage carries no reset: entries are only meaningful below count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cache_mem[wr_ptr_q] <= pf_cache_addr;
      fifo_main_mem[wr_ptr_q]  <= pf_main_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Arbitration, issue register and state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    req_cache_d = req_cache_q;
    req_main_d  = req_main_q;
    req_write_d = req_write_q;
    req_src_d   = req_src_q;
    dm_ready_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (take_pf) begin
          req_cache_d = fifo_cache_mem[rd_ptr_q];
          req_main_d  = fifo_main_mem[rd_ptr_q];
          req_write_d = 1'b0;
          req_src_d   = 1'b1;
          starve_d    = '0;
          state_d     = ST_ISSUE_PF;
        end else if (take_dm) begin
          req_cache_d = dm_cache_addr;
          req_main_d  = dm_main_addr;
          req_write_d = dm_is_write;
          req_src_d   = 1'b0;
          dm_ready_d  = 1'b1;
          state_d     = ST_ISSUE_DM;
          // Only demand grants that overtook a waiting prefetch count
          // towards starvation.
          if (fifo_empty) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
          end
        end
      end
      ST_ISSUE_DM, ST_ISSUE_PF: begin
        if (mem_req_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (flush) begin
      starve_d = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight tracking and completion pulse
  // ---------------------------------------------------------------------------
  always_comb begin
    case ({req_hs, resp_ok})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase
    dm_done_d = resp_ok && !mem_resp_src;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= ST_IDLE;
      starve_q      <= '0;
      outstanding_q <= '0;
      req_cache_q   <= '0;
      req_main_q    <= '0;
      req_write_q   <= 1'b0;
      req_src_q     <= 1'b0;
      dm_ready_q    <= 1'b0;
      dm_done_q     <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      starve_q      <= starve_d;
      outstanding_q <= outstanding_d;
      req_cache_q   <= req_cache_d;
      req_main_q    <= req_main_d;
      req_write_q   <= req_write_d;
      req_src_q     <= req_src_d;
      dm_ready_q    <= dm_ready_d;
      dm_done_q     <= dm_done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign pf_ready      = !fifo_full;
  assign dm_ready      = dm_ready_q;
  assign mem_req_valid = (state_q == ST_ISSUE_DM) || (state_q == ST_ISSUE_PF);
  assign mem_req_cache = req_cache_q;
  assign mem_req_main  = req_main_q;
  assign mem_req_write = req_write_q;
  assign mem_req_src   = req_src_q;
  assign dm_done       = dm_done_q;
  assign outstanding   = outstanding_q;

endmodule

// File: tb/tb_dma_prefetch_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dma_prefetch_scheduler
//
// Drives directed scenarios (demand only, starvation order, outstanding cap,
// FIFO full, flush, asynchronous reset) followed by a randomized run. Every
// cycle the DUT outputs are compared with a transaction-level reference model
// built from queues: a prefetch queue, an in-flight source queue, one pending
// request slot, a starvation counter and an in-flight count.
// -----------------------------------------------------------------------------
module tb_dma_prefetch_scheduler;

  localparam int MAXO  = 4;
  localparam int LIMIT = 3;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        pf_valid;
  logic        pf_ready;
  logic [17:0] pf_cache_addr;
  logic [17:0] pf_main_addr;
  logic        dm_valid;
  logic        dm_ready;
  logic [17:0] dm_cache_addr;
  logic [17:0] dm_main_addr;
  logic        dm_is_write;
  logic        flush;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [17:0] mem_req_cache;
  logic [17:0] mem_req_main;
  logic        mem_req_write;
  logic        mem_req_src;
  logic        mem_resp_valid;
  logic        mem_resp_src;
  logic        dm_done;
  logic [3:0]  outstanding;

  always #5 clk = ~clk;

  dma_prefetch_scheduler #(
    .LOG_PF_DEPTH   (2),
    .MAX_OUTSTANDING(MAXO),
    .STARVE_LIMIT   (LIMIT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .pf_valid      (pf_valid),
    .pf_ready      (pf_ready),
    .pf_cache_addr (pf_cache_addr),
    .pf_main_addr  (pf_main_addr),
    .dm_valid      (dm_valid),
    .dm_ready      (dm_ready),
    .dm_cache_addr (dm_cache_addr),
    .dm_main_addr  (dm_main_addr),
    .dm_is_write   (dm_is_write),
    .flush         (flush),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_cache (mem_req_cache),
    .mem_req_main  (mem_req_main),
    .mem_req_write (mem_req_write),
    .mem_req_src   (mem_req_src),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_src  (mem_resp_src),
    .dm_done       (dm_done),
    .outstanding   (outstanding)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [17:0] cache;
    logic [17:0] main;
    logic        wr;
    logic        src;
  } req_t;

  req_t pfq[$];        // queued prefetches, oldest first
  bit   inflight[$];   // sources of issued, unanswered transfers
  bit   m_busy;        // a request is presented on the DMA port
  req_t m_pend;        // the presented request
  int   m_starve;
  int   m_outs;
  bit   m_dmr;
  bit   m_done;

  function automatic void model_reset();
    pfq.delete();
    inflight.delete();
    m_busy   = 1'b0;
    m_pend   = '0;
    m_starve = 0;
    m_outs   = 0;
    m_dmr    = 1'b0;
    m_done   = 1'b0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_step();
    bit hs       = m_busy && mem_req_ready;
    bit rsp      = mem_resp_valid && (m_outs > 0);
    bit pf_ok    = pf_valid && (pfq.size() < DEPTH) && !flush;
    bit had_pf   = (pfq.size() > 0);
    bit pf_avail = had_pf && !flush;
    m_done = rsp && (mem_resp_src == 1'b0);
    m_dmr  = 1'b0;
    if (rsp) void'(inflight.pop_front());
    if (m_busy) begin
      if (hs) begin
        inflight.push_back(m_pend.src);
        m_busy = 1'b0;
      end
    end else if (m_outs < MAXO) begin
      if (pf_avail && (m_starve == LIMIT || !dm_valid)) begin
        m_pend   = pfq.pop_front();
        m_busy   = 1'b1;
        m_starve = 0;
      end else if (dm_valid) begin
        m_pend   = '{dm_cache_addr, dm_main_addr, dm_is_write, 1'b0};
        m_busy   = 1'b1;
        m_dmr    = 1'b1;
        m_starve = had_pf ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end
    end
    m_outs = m_outs + (hs ? 1 : 0) - (rsp ? 1 : 0);
    if (flush) begin
      pfq.delete();
      m_starve = 0;
    end
    if (pf_ok) pfq.push_back('{pf_cache_addr, pf_main_addr, 1'b0, 1'b1});
  endfunction

  task automatic compare_outputs();
    check_val("mem_req_valid", mem_req_valid, m_busy);
    if (m_busy) begin
      check_val("mem_req_cache", mem_req_cache, m_pend.cache);
      check_val("mem_req_main", mem_req_main, m_pend.main);
      check_val("mem_req_write", mem_req_write, m_pend.wr);
      check_val("mem_req_src", mem_req_src, m_pend.src);
    end
    check_val("dm_ready", dm_ready, m_dmr);
    check_val("pf_ready", pf_ready, pfq.size() < DEPTH);
    check_val("outstanding", outstanding, m_outs);
    check_val("dm_done", dm_done, m_done);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (called at the falling edge)
  // ---------------------------------------------------------------------------
  bit rec_grants;
  bit grants[$];
  int dm_budget;
  int cyc = 0;

  task automatic tick();
    if (rec_grants && mem_req_valid && mem_req_ready) grants.push_back(mem_req_src);
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_outputs();
    $display("cyc %0d: req v=%0b src=%0b main=%05h rdy=%0b | dm_ready=%0b pf_ready=%0b out=%0d done=%0b",
             cyc, mem_req_valid, mem_req_src, mem_req_main, mem_req_ready,
             dm_ready, pf_ready, outstanding, dm_done);
  endtask

  task automatic new_demand();
    dm_valid      = 1'b1;
    dm_cache_addr = 18'($urandom);
    dm_main_addr  = 18'($urandom);
    dm_is_write   = 1'($urandom_range(1));
  endtask

  task automatic new_pf();
    pf_cache_addr = 18'($urandom);
    pf_main_addr  = 18'($urandom);
  endtask

  // Demand source: holds its request until captured, then maybe offers another.
  task automatic dm_drive(input int pct);
    if (dm_valid && m_dmr) dm_valid = 1'b0;
    if (!dm_valid && dm_budget > 0 && $urandom_range(99) < pct) begin
      new_demand();
      dm_budget--;
    end
  endtask

  // Answers the oldest in-flight transfer with probability pct.
  task automatic drive_resp(input int pct);
    mem_resp_valid = 1'b0;
    mem_resp_src   = 1'b0;
    if (inflight.size() > 0 && $urandom_range(99) < pct) begin
      mem_resp_valid = 1'b1;
      mem_resp_src   = inflight[0];
    end
  endtask

  task automatic drain();
    dm_budget     = 0;
    pf_valid      = 1'b0;
    flush         = 1'b0;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 60 && (dm_valid || m_busy || inflight.size() > 0 || pfq.size() > 0); i++) begin
      drive_resp(100);
      tick();
      dm_drive(0);
    end
    drive_resp(0);
    check_val("drain_outstanding", outstanding, 0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  bit exp_order[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int n_dmr;
  int n_push;
  bit acc;

  initial begin
    reset          = 1'b1;
    pf_valid       = 1'b0;
    pf_cache_addr  = '0;
    pf_main_addr   = '0;
    dm_valid       = 1'b0;
    dm_cache_addr  = '0;
    dm_main_addr   = '0;
    dm_is_write    = 1'b0;
    flush          = 1'b0;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_src   = 1'b0;
    rec_grants     = 1'b0;
    dm_budget      = 0;
    model_reset();

    // Reset state
    repeat (2) @(negedge clk);
    compare_outputs();
    check_val("rst_pf_ready", pf_ready, 1);
    check_val("rst_req_main", mem_req_main, 0);
    reset = 1'b0;

    // Demand only
    dm_cache_addr = 18'h20;
    dm_main_addr  = 18'h100;
    dm_is_write   = 1'b0;
    dm_valid      = 1'b1;
    mem_req_ready = 1'b1;
    tick();
    check_val("demand_dm_ready", dm_ready, 1);
    check_val("demand_req_valid", mem_req_valid, 1);
    check_val("demand_req_src", mem_req_src, 0);
    check_val("demand_req_main", mem_req_main, 18'h100);
    check_val("demand_req_cache", mem_req_cache, 18'h20);
    dm_valid = 1'b0;
    tick();
    check_val("demand_outstanding", outstanding, 1);
    drive_resp(100);
    tick();
    drive_resp(0);
    check_val("demand_dm_done", dm_done, 1);
    check_val("demand_out_after_resp", outstanding, 0);

    // Starvation: two prefetches queue up behind a stalled demand
    mem_req_ready = 1'b0;
    dm_budget     = 100;
    dm_drive(100);
    pf_valid = 1'b1;
    new_pf();
    tick();
    new_pf();
    dm_drive(100);
    tick();
    pf_valid = 1'b0;
    dm_drive(100);
    grants.delete();
    rec_grants    = 1'b1;
    mem_req_ready = 1'b1;
    for (int i = 0; i < 80 && grants.size() < 9; i++) begin
      drive_resp(100);
      tick();
      dm_drive(100);
    end
    rec_grants = 1'b0;
    check_val("starve_grant_count", grants.size() >= 9, 1);
    for (int i = 0; i < 9 && i < grants.size(); i++)
      check_val($sformatf("starve_order[%0d]", i), grants[i], exp_order[i]);
    drain();

    // Outstanding cap: five demands, no responses
    dm_budget     = 5;
    n_dmr         = 0;
    mem_req_ready = 1'b1;
    dm_drive(100);
    repeat (30) begin
      drive_resp(0);
      tick();
      if (dm_ready) n_dmr++;
      dm_drive(100);
    end
    check_val("cap_issued", n_dmr, 4);
    check_val("cap_outstanding", outstanding, 4);
    check_val("cap_req_idle", mem_req_valid, 0);
    drive_resp(100);
    tick();
    if (dm_ready) n_dmr++;
    dm_drive(100);
    repeat (6) begin
      drive_resp(0);
      tick();
      if (dm_ready) n_dmr++;
      dm_drive(100);
    end
    check_val("cap_after_resp", n_dmr, 5);
    check_val("cap_outstanding_again", outstanding, 4);

    // FIFO full: no grants possible while the cap is reached
    mem_req_ready = 1'b0;
    pf_valid      = 1'b1;
    new_pf();
    n_push = 0;
    for (int i = 0; i < 14; i++) begin
      drive_resp(i == 8 ? 100 : 0);
      acc = pf_valid && pf_ready;
      tick();
      if (acc) begin
        n_push++;
        if (n_push < 5) new_pf();
        else pf_valid = 1'b0;
      end
      if (i == 7) begin
        check_val("full_pushes", n_push, 4);
        check_val("full_pf_ready", pf_ready, 0);
      end
    end
    drive_resp(0);
    check_val("full_fifth_accepted", n_push, 5);
    check_val("full_pf_issue_held", mem_req_valid, 1);
    check_val("full_pf_issue_src", mem_req_src, 1);

    // Flush while a prefetch sits unaccepted on the port
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_val("flush_pf_ready", pf_ready, 1);
    check_val("flush_req_kept", mem_req_valid, 1);
    grants.delete();
    rec_grants    = 1'b1;
    mem_req_ready = 1'b1;
    repeat (10) begin
      drive_resp(50);
      tick();
    end
    rec_grants = 1'b0;
    check_val("flush_grant_count", grants.size(), 1);
    if (grants.size() > 0) check_val("flush_grant_src", grants[0], 1);
    drain();

    // Randomized traffic
    dm_budget = 1000000;
    repeat (1500) begin
      mem_req_ready = 1'($urandom_range(99) < 60);
      pf_valid      = 1'($urandom_range(99) < 40);
      new_pf();
      flush         = 1'($urandom_range(99) < 2);
      drive_resp(40);
      tick();
      dm_drive(50);
    end
    drain();

    // Asynchronous reset with two transfers in flight and one on the port
    dm_budget = 100;
    for (int i = 0; i < 60 && !(m_outs == 2 && m_busy); i++) begin
      mem_req_ready = 1'(m_outs < 2);
      drive_resp(0);
      tick();
      dm_drive(100);
    end
    check_val("pre_rst_outstanding", outstanding, 2);
    check_val("pre_rst_req_valid", mem_req_valid, 1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_req_valid", mem_req_valid, 0);
    check_val("arst_pf_ready", pf_ready, 1);
    check_val("arst_outstanding", outstanding, 0);
    check_val("arst_dm_ready", dm_ready, 0);
    check_val("arst_req_main", mem_req_main, 0);
    check_val("arst_req_cache", mem_req_cache, 0);
    dm_valid      = 1'b0;
    dm_budget     = 0;
    mem_req_ready = 1'b0;
    drive_resp(0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    compare_outputs();
    dm_budget     = 1;
    mem_req_ready = 1'b1;
    dm_drive(100);
    repeat (4) begin
      tick();
      dm_drive(100);
    end
    check_val("post_rst_outstanding", outstanding, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
